// File: rtl/vga_cell_renderer.sv
// Scans a 64x48 cell grid out as 640x480@60 VGA, one row fetch per line.
// Optional GRID_LINES_EN draws a 1-px 12'h333 grid on cell left/top edges.
module vga_cell_renderer #(
  parameter int          H_VISIBLE = 640,
  parameter int          H_FP      = 16,
  parameter int          H_SYNC    = 96,
  parameter int          H_BP      = 48,
  parameter int          V_VISIBLE = 480,
  parameter int          V_FP      = 10,
  parameter int          V_SYNC    = 2,
  parameter int          V_BP      = 33,
  parameter int          CELL_PX   = 10,
  parameter int          PIX_DIV   = 4,
  parameter logic [11:0] ALIVE_RGB = 12'hFFF,
  parameter logic [11:0] DEAD_RGB  = 12'h000
) (
  input  logic        sys_clk,
  input  logic        Reset_n,
  output logic [5:0]  row_addr,
  input  logic [63:0] row_data,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] vga_rgb,
  output logic        frame_tick
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int SW = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
  localparam int CW_R = $clog2(H_TOTAL / CELL_PX + 1);
  localparam int CW = (CW_R < 6) ? 6 : CW_R;
  localparam int RW_R = $clog2(V_TOTAL / CELL_PX + 1);
  localparam int RW = (RW_R < 6) ? 6 : RW_R;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_BEG   = HW'(H_VISIBLE + H_FP);
  localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_VIS_M1 = VW'(V_VISIBLE - 1);
  localparam logic [VW-1:0] VS_BEG   = VW'(V_VISIBLE + V_FP);
  localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [SW-1:0] SUB_LAST = SW'(CELL_PX - 1);

  logic [DW-1:0] div;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [SW-1:0] hsub;
  logic [SW-1:0] vsub;
  logic [CW-1:0] hcol;
  logic [RW-1:0] vrow;
  logic [63:0]   line_buf;

  logic          pix_ce;
  logic          h_wrap;
  logic          v_wrap;
  logic          visible;
  logic [RW-1:0] fetch_row;
  logic [11:0]   pix_rgb;

  assign pix_ce = (div == DIV_LAST);
  assign h_wrap = (h == H_LAST);
  assign v_wrap = (v == V_LAST);

  // Cell row of line v+1; blank lines and the frame wrap fetch row 0.
  always_comb begin
    fetch_row = '0;
    if (v < V_VIS_M1)
      fetch_row = (vsub == SUB_LAST) ? vrow + RW'(1) : vrow;
  end

  always_comb begin
    visible = (h < H_VIS) && (v < V_VIS);
    pix_rgb = 12'h000;
    if (visible) begin
      pix_rgb = line_buf[hcol[5:0]] ? ALIVE_RGB : DEAD_RGB;
`ifdef GRID_LINES_EN
      if ((hsub == '0) || (vsub == '0))
        pix_rgb = 12'h333;
`endif
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!Reset_n) begin
      div  <= '0;
      h    <= '0;
      v    <= '0;
      hsub <= '0;
      vsub <= '0;
      hcol <= '0;
      vrow <= '0;
    end else begin
      div <= pix_ce ? '0 : div + DW'(1);
      if (pix_ce) begin
        if (h_wrap) begin
          h    <= '0;
          hsub <= '0;
          hcol <= '0;
          if (v_wrap) begin
            v    <= '0;
            vsub <= '0;
            vrow <= '0;
          end else begin
            v <= v + VW'(1);
            if (vsub == SUB_LAST) begin
              vsub <= '0;
              vrow <= vrow + RW'(1);
            end else begin
              vsub <= vsub + SW'(1);
            end
          end
        end else begin
          h <= h + HW'(1);
          if (hsub == SUB_LAST) begin
            hsub <= '0;
            hcol <= hcol + CW'(1);
          end else begin
            hsub <= hsub + SW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!Reset_n) begin
      row_addr   <= '0;
      line_buf   <= '0;
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      vga_rgb    <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= pix_ce && (h == '0) && (v == V_VIS);
      if (pix_ce) begin
        vga_rgb <= pix_rgb;
        hsync   <= !((h >= HS_BEG) && (h <= HS_END));
        vsync   <= !((v >= VS_BEG) && (v <= VS_END));
        if (h == H_VIS)
          row_addr <= fetch_row[5:0];
        if (h_wrap)
          line_buf <= row_data;
      end
    end
  end

endmodule
